// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 register-file target.
package spi_target_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    DATA_RD = 3'd3,
    DATA_WR = 3'd4,
    IGNORE  = 3'd5
  } state_e;

  localparam logic [7:0] CMD_READ_DEF  = 8'h03;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

  // Minimum SCK period in system clocks for the oversampled edge detect.
  localparam int SCK_MIN_DIV = 8;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer with a history flop; reports level and one-cycle rise/fall.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, hist_q;
  logic s1_d, s2_d, hist_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    hist_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~hist_q;
  assign fall  = ~s2_q & hist_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target backed by a byte register file, with a local read/write port.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF,
  localparam int        AW        = $clog2(DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          spi_clk,
  input  logic          spi_cs,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  input  logic          loc_we,
  output logic [7:0]    loc_rdata,
  output logic          spi_wr,
  output logic [AW-1:0] spi_wr_addr,
  output logic          xfer_done
);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(spi_clk),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(spi_cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};

  state_e                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     rd_q, rd_d;
  logic [7:0]               sh_q, sh_d;
  logic [7:0]               tx_q, tx_d;
  logic                     miso_q, miso_d;
  logic                     oe_q, oe_d;
  logic                     wr_q, wr_d;
  logic [AW-1:0]            wr_addr_q, wr_addr_d;
  logic                     done_q, done_d;
  logic [DEPTH-1:0][7:0]    mem_q, mem_d;

  logic          commit;
  logic          sck_rise_v, sck_fall_v;
  logic [7:0]    rx_byte;
  logic [AW-1:0] rx_addr, addr_inc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    done_d    = 1'b0;
    commit    = 1'b0;
    sck_rise_v = sck_rise & ~cs_lvl;
    sck_fall_v = sck_fall & ~cs_lvl;
    rx_byte   = {sh_q[6:0], mosi_lvl};
    rx_addr   = rx_byte[AW-1:0];
    addr_inc  = addr_q + AW'(1);

    // CS release wins over any SCK edge seen in the same cycle.
    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      done_d  = 1'b1;
    end else if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d = CMD;
        cnt_d   = 3'd0;
        oe_d    = 1'b1;
        miso_d  = 1'b0;
      end
    end else if (sck_rise_v) begin
      sh_d  = rx_byte;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        case (state_q)
          CMD: begin
            if (rx_byte == CMD_READ) begin
              state_d = ADDR;
              rd_d    = 1'b1;
            end else if (rx_byte == CMD_WRITE) begin
              state_d = ADDR;
              rd_d    = 1'b0;
            end else begin
              state_d = IGNORE;
            end
          end
          ADDR: begin
            addr_d = rx_addr;
            if (rd_q) begin
              tx_d    = mem_q[rx_addr];
              state_d = DATA_RD;
            end else begin
              state_d = DATA_WR;
            end
          end
          DATA_RD: begin
            addr_d = addr_inc;
            tx_d   = mem_q[addr_inc];
          end
          DATA_WR: begin
            commit    = 1'b1;
            wr_d      = 1'b1;
            wr_addr_d = addr_q;
            addr_d    = addr_inc;
          end
          default: ;
        endcase
      end
    end else if (sck_fall_v && state_q == DATA_RD) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end

    // SPI commit is applied last so it overrides a same-address local write.
    mem_d = mem_q;
    if (loc_we) mem_d[loc_addr] = loc_wdata;
    if (commit) mem_d[addr_q] = rx_byte;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      sh_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      mem_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
      mem_q     <= mem_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign spi_wr      = wr_q;
  assign spi_wr_addr = wr_addr_q;
  assign xfer_done   = done_q;
  assign loc_rdata   = mem_q[loc_addr];

endmodule
